// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle ARM-subset control unit:
// state encoding, ALU codes, datapath select encodings and condition fields.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_RSB  = 3'b010;
  localparam logic [2:0] ALU_BIC  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_ORR  = 3'b101;
  localparam logic [2:0] ALU_EOR  = 3'b110;
  localparam logic [2:0] ALU_XNOR = 3'b111;

  localparam logic [1:0] SRCA_RN     = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;
  localparam logic [1:0] SRCB_RM     = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       compare;
    logic [2:0] code;
  } cmd_dec_t;

  function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
    cmd_dec_t d;
    d.valid   = 1'b1;
    d.compare = 1'b0;
    d.code    = ALU_ADD;
    case (cmd)
      4'b0000: d.code = ALU_AND;
      4'b0001: d.code = ALU_EOR;
      4'b0010: d.code = ALU_SUB;
      4'b0011: d.code = ALU_RSB;
      4'b0100: d.code = ALU_ADD;
      4'b1100: d.code = ALU_ORR;
      4'b1110: d.code = ALU_BIC;
      4'b1010: begin d.code = ALU_SUB; d.compare = 1'b1; end
      4'b1001: begin d.code = ALU_EOR; d.compare = 1'b1; end
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

  // Add/sub style codes produce meaningful carry and overflow.
  function automatic logic is_arith(input logic [2:0] code);
    return (code == ALU_ADD) || (code == ALU_SUB) || (code == ALU_RSB);
  endfunction

  function automatic ctrl_t state_ctrl(input state_t st, input logic rd_pc,
                                       input logic [2:0] dp_code,
                                       input logic [2:0] none_code);
    ctrl_t c;
    c = '0;
    c.alu_ctrl = none_code;
    case (st)
      S_FETCH: begin
        c.ir_write = 1'b1; c.pc_write = 1'b1;
        c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALU;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALU;
      end
      S_MEMADR: begin c.alu_src_a = SRCA_RN; c.alu_src_b = SRCB_IMM; end
      S_MEMRD:  c.adr_src = 1'b1;
      S_MEMWR:  begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_MEMWB:  begin c.result_src = RES_DATA; c.reg_write = 1'b1; c.pc_write = rd_pc; end
      S_EXECR:  begin c.alu_src_a = SRCA_RN; c.alu_src_b = SRCB_RM; c.alu_ctrl = dp_code; end
      S_EXECI:  begin c.alu_src_a = SRCA_RN; c.alu_src_b = SRCB_IMM; c.alu_ctrl = dp_code; end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT; c.reg_write = 1'b1; c.pc_write = rd_pc; c.alu_ctrl = dp_code;
      end
      S_BRANCH: begin
        c.alu_src_a = SRCA_ALUOUT; c.alu_src_b = SRCB_IMM; c.result_src = RES_ALU;
        c.pc_write = 1'b1;
      end
      default: c.alu_ctrl = none_code;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_cond_check.sv
// Combinational ARM condition-code evaluation of Cond against {N,Z,C,V}.
// With COND_EN=0 every condition passes.
module mc_cond_check
  import mc_pkg::*;
#(
  parameter bit COND_EN = 1'b1
) (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n_s, z_s, c_s, v_s, eval_s;

  assign {n_s, z_s, c_s, v_s} = flags;

  // Condition truth table; NV never executes.
  always_comb begin
    eval_s = 1'b0;
    case (cond)
      COND_EQ: eval_s = z_s;
      COND_NE: eval_s = ~z_s;
      COND_CS: eval_s = c_s;
      COND_CC: eval_s = ~c_s;
      COND_MI: eval_s = n_s;
      COND_PL: eval_s = ~n_s;
      COND_VS: eval_s = v_s;
      COND_VC: eval_s = ~v_s;
      COND_HI: eval_s = c_s & ~z_s;
      COND_LS: eval_s = ~c_s | z_s;
      COND_GE: eval_s = (n_s == v_s);
      COND_LT: eval_s = (n_s != v_s);
      COND_GT: eval_s = ~z_s & (n_s == v_s);
      COND_LE: eval_s = z_s | (n_s != v_s);
      COND_AL: eval_s = 1'b1;
      COND_NV: eval_s = 1'b0;
      default: eval_s = 1'b0;
    endcase
  end

  assign pass = eval_s | ~COND_EN;

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM with NZCV flag register for the ARM-subset core.
// Define MC_COND_EXEC_EN to enable conditional execution; otherwise all Cond = AL.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter logic [2:0] NONE_CMD = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [2:0]  ALU_Control,
  output logic [3:0]  Flags
);

`ifdef MC_COND_EXEC_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif

  state_t     state_r, next_state_s, target_state_s;
  logic       hold_r;
  ctrl_t      ctrl_r, ctrl_s;
  logic [3:0] flags_r, flags_next_s;
  cmd_dec_t   cmd_dec_s;
  logic       cond_pass_s;

  logic [3:0] cond_s, cmd_s;
  logic [1:0] op_s;
  logic       i_bit_s, s_bit_s, rd_pc_s, unused_rn_s;

  assign cond_s      = Instr[19:16];
  assign op_s        = Instr[15:14];
  assign i_bit_s     = Instr[13];
  assign cmd_s       = Instr[12:9];
  assign s_bit_s     = Instr[8];
  assign rd_pc_s     = (Instr[3:0] == 4'hF);
  assign unused_rn_s = ^Instr[7:4];

  mc_cond_check #(.COND_EN(COND_EN)) u_cond (
    .cond  (cond_s),
    .flags (flags_r),
    .pass  (cond_pass_s)
  );

  // Next state, next-cycle control word and flag update.
  always_comb begin
    cmd_dec_s    = decode_cmd(cmd_s);
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH: next_state_s = S_DECODE;
      S_DECODE: begin
        if (!cond_pass_s) begin
          next_state_s = S_FETCH;
        end else begin
          case (op_s)
            OP_MEM: next_state_s = S_MEMADR;
            OP_BR:  next_state_s = S_BRANCH;
            OP_DP: begin
              if (!cmd_dec_s.valid) next_state_s = S_FETCH;
              else if (i_bit_s)     next_state_s = S_EXECI;
              else                  next_state_s = S_EXECR;
            end
            default: next_state_s = S_FETCH;
          endcase
        end
      end
      S_MEMADR: next_state_s = s_bit_s ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state_s = S_MEMWB;
      S_EXECR, S_EXECI: next_state_s = cmd_dec_s.compare ? S_FETCH : S_ALUWB;
      default:  next_state_s = S_FETCH;
    endcase

    // The first cycle out of reset is a clean FETCH with no carry-over.
    if (hold_r) target_state_s = S_FETCH;
    else        target_state_s = next_state_s;

    ctrl_s = state_ctrl(target_state_s, rd_pc_s, cmd_dec_s.code, NONE_CMD);

    flags_next_s = flags_r;
    if ((state_r == S_EXECR || state_r == S_EXECI) && s_bit_s) begin
      if (is_arith(cmd_dec_s.code)) flags_next_s = ALUFlags;
      else                          flags_next_s = {ALUFlags[3:2], flags_r[1:0]};
    end else begin
      flags_next_s = flags_r;
    end
  end

  // State, registered control outputs and architectural flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
      hold_r  <= 1'b1;
      ctrl_r  <= '0;
      flags_r <= 4'b0000;
    end else begin
      state_r <= target_state_s;
      hold_r  <= 1'b0;
      ctrl_r  <= ctrl_s;
      flags_r <= flags_next_s;
    end
  end

  assign IRWrite     = ctrl_r.ir_write;
  assign PCWrite     = ctrl_r.pc_write;
  assign RegWrite    = ctrl_r.reg_write;
  assign MemWrite    = ctrl_r.mem_write;
  assign AdrSrc      = ctrl_r.adr_src;
  assign ALUSrcA     = ctrl_r.alu_src_a;
  assign ALUSrcB     = ctrl_r.alu_src_b;
  assign ResultSrc   = ctrl_r.result_src;
  assign ALU_Control = ctrl_r.alu_ctrl;
  assign Flags       = flags_r;
  assign ImmSrc      = op_s;
  assign RegSrc      = op_s;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed scoreboard bench for mc_control_fsm: per-cycle expected control
// words are queued per instruction and compared one cycle at a time.
module tb_mc_control_fsm;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0]  ALU_Control;
  logic [3:0]  Flags;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALU_Control(ALU_Control), .Flags(Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed word: {IRW,PCW,RegW,MemW,AdrSrc,SrcA,SrcB,ResultSrc,ALU_Control,Flags}
  typedef struct {
    string       tag;
    logic [17:0] val;
    logic [17:0] mask;
  } ent_t;

  localparam logic [17:0] K_ALL    = 18'h3FFFF;
  localparam logic [17:0] K_NOADR  = 18'h3DFFF;
  localparam logic [17:0] K_ALUFL  = 18'h3C07F;
  localparam logic [17:0] K_MEMRD  = 18'h3E00F;
  localparam logic [17:0] K_ENFL   = 18'h3C00F;
  localparam logic [17:0] K_WB     = 18'h3C18F;

`ifdef MC_COND_EXEC_EN
  localparam logic [3:0] FL_BEFORE_RST = 4'b1010;
`else
  localparam logic [3:0] FL_BEFORE_RST = 4'b0001;
`endif

  ent_t  sbq[$];
  int    total = 0;
  int    bad = 0;
  string cur = "init";

  function automatic logic [17:0] mk(input logic [3:0] en, input logic adr,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] rs, input logic [2:0] alu,
                                     input logic [3:0] fl);
    return {en, adr, sa, sb, rs, alu, fl};
  endfunction

  function automatic logic [19:0] ins(input logic [3:0] cond, input logic [1:0] op,
                                      input logic [5:0] funct, input logic [3:0] rd);
    return {cond, op, funct, 4'h0, rd};
  endfunction

  task automatic push(input string tag, input logic [17:0] val, input logic [17:0] mask);
    ent_t e;
    e.tag = tag; e.val = val; e.mask = mask;
    sbq.push_back(e);
  endtask

  task automatic p_rst(input logic [3:0] fl);    push("reset",  mk(4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, fl), K_ENFL);  endtask
  task automatic p_fetch(input logic [3:0] fl);  push("fetch",  mk(4'b1100, 1'b0, 2'b01, 2'b10, 2'b10, 3'b000, fl), K_ALL);   endtask
  task automatic p_decode(input logic [3:0] fl); push("decode", mk(4'b0000, 1'b0, 2'b01, 2'b10, 2'b10, 3'b000, fl), K_NOADR); endtask
  task automatic p_branch(input logic [3:0] fl); push("branch", mk(4'b0100, 1'b0, 2'b10, 2'b01, 2'b10, 3'b000, fl), K_NOADR); endtask
  task automatic p_memadr(input logic [3:0] fl); push("memadr", mk(4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, fl), K_ALUFL); endtask
  task automatic p_memrd(input logic [3:0] fl);  push("memrd",  mk(4'b0000, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, fl), K_MEMRD); endtask
  task automatic p_memwr(input logic [3:0] fl);  push("memwr",  mk(4'b0001, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, fl), K_ENFL);  endtask
  task automatic p_memwb(input logic [3:0] fl, input logic pc);
    push("memwb", mk({1'b0, pc, 2'b10}, 1'b0, 2'b00, 2'b00, 2'b01, 3'b000, fl), K_WB);
  endtask
  task automatic p_exec(input logic [2:0] alu, input logic [3:0] fl);
    push("exec", mk(4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, alu, fl), K_ALUFL);
  endtask
  task automatic p_aluwb(input logic [3:0] fl, input logic pc);
    push("aluwb", mk({1'b0, pc, 2'b10}, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, fl), K_WB);
  endtask

  task automatic check();
    ent_t e;
    logic [17:0] obs;
    obs = {IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALU_Control, Flags};
    total++;
    assert (sbq.size() != 0) else begin
      bad++;
      $error("FAIL %s/no_expectation observed=%h expected=queued_entry", cur, obs);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      assert ((obs & e.mask) === (e.val & e.mask)) else begin
        bad++;
        $error("FAIL %s/%s observed=%h expected=%h", cur, e.tag, obs & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    check();
  endtask

  // Load the instruction as the IR would (entering DECODE), then drain the queue.
  task automatic run(input logic [19:0] instr, input logic [3:0] af);
    @(posedge clk); #1;
    Instr    = instr;
    ALUFlags = af;
    check();
    while (sbq.size() > 0) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Instr = 20'h0; ALUFlags = 4'b0000;

    cur = "reset_init";
    p_rst(4'b0000); p_rst(4'b0000);
    step(); step();
    reset = 1'b0;
    p_fetch(4'b0000);
    step();

    cur = "adds";
    p_decode(4'b0000); p_exec(3'b000, 4'b0000); p_aluwb(4'b0110, 1'b0); p_fetch(4'b0110);
    run(ins(4'b1110, 2'b00, 6'b001001, 4'd1), 4'b0110);

    cur = "subs";
    p_decode(4'b0110); p_exec(3'b001, 4'b0110); p_aluwb(4'b0100, 1'b0); p_fetch(4'b0100);
    run(ins(4'b1110, 2'b00, 6'b000101, 4'd2), 4'b0100);

    cur = "ands";
    p_decode(4'b0100); p_exec(3'b100, 4'b0100); p_aluwb(4'b1000, 1'b0); p_fetch(4'b1000);
    run(ins(4'b1110, 2'b00, 6'b000001, 4'd2), 4'b1000);

    cur = "adds_cv";
    p_decode(4'b1000); p_exec(3'b000, 4'b1000); p_aluwb(4'b0111, 1'b0); p_fetch(4'b0111);
    run(ins(4'b1110, 2'b00, 6'b001001, 4'd3), 4'b0111);

    cur = "orrs_imm_hold_cv";
    p_decode(4'b0111); p_exec(3'b101, 4'b0111); p_aluwb(4'b1011, 1'b0); p_fetch(4'b1011);
    run(ins(4'b1110, 2'b00, 6'b111001, 4'd4), 4'b1000);

    cur = "add_nos";
    p_decode(4'b1011); p_exec(3'b000, 4'b1011); p_aluwb(4'b1011, 1'b0); p_fetch(4'b1011);
    run(ins(4'b1110, 2'b00, 6'b001000, 4'd5), 4'b1111);

    cur = "add_rd15";
    p_decode(4'b1011); p_exec(3'b000, 4'b1011); p_aluwb(4'b1011, 1'b1); p_fetch(4'b1011);
    run(ins(4'b1110, 2'b00, 6'b001000, 4'd15), 4'b0000);

    cur = "ldr";
    p_decode(4'b1011); p_memadr(4'b1011); p_memrd(4'b1011); p_memwb(4'b1011, 1'b0); p_fetch(4'b1011);
    run(ins(4'b1110, 2'b01, 6'b000001, 4'd3), 4'b0000);
    total++;
    assert ({ImmSrc, RegSrc} === 4'b0101) else begin
      bad++;
      $error("FAIL ldr/imm_reg_src observed=%b expected=%b", {ImmSrc, RegSrc}, 4'b0101);
    end

    cur = "ldr_pc";
    p_decode(4'b1011); p_memadr(4'b1011); p_memrd(4'b1011); p_memwb(4'b1011, 1'b1); p_fetch(4'b1011);
    run(ins(4'b1110, 2'b01, 6'b000001, 4'd15), 4'b0000);

    cur = "str";
    p_decode(4'b1011); p_memadr(4'b1011); p_memwr(4'b1011); p_fetch(4'b1011);
    run(ins(4'b1110, 2'b01, 6'b000000, 4'd3), 4'b0000);

    cur = "cmp";
    p_decode(4'b1011); p_exec(3'b001, 4'b1011); p_fetch(4'b0110);
    run(ins(4'b1110, 2'b00, 6'b010101, 4'd0), 4'b0110);

    cur = "bne_zset";
    p_decode(4'b0110);
`ifndef MC_COND_EXEC_EN
    p_branch(4'b0110);
`endif
    p_fetch(4'b0110);
    run(ins(4'b0001, 2'b10, 6'b000000, 4'd0), 4'b0000);

    cur = "beq_zset";
    p_decode(4'b0110); p_branch(4'b0110); p_fetch(4'b0110);
    run(ins(4'b0000, 2'b10, 6'b000000, 4'd0), 4'b0000);

    cur = "teq";
    p_decode(4'b0110); p_exec(3'b110, 4'b0110); p_fetch(4'b1010);
    run(ins(4'b1110, 2'b00, 6'b010011, 4'd0), 4'b1000);

    cur = "op11_undef";
    p_decode(4'b1010); p_fetch(4'b1010);
    run(ins(4'b1110, 2'b11, 6'b001001, 4'd1), 4'b1111);

    cur = "cmd_undef";
    p_decode(4'b1010); p_fetch(4'b1010);
    run(ins(4'b1110, 2'b00, 6'b001011, 4'd1), 4'b1111);

    cur = "bge_n_ne_v";
    p_decode(4'b1010);
`ifndef MC_COND_EXEC_EN
    p_branch(4'b1010);
`endif
    p_fetch(4'b1010);
    run(ins(4'b1010, 2'b10, 6'b000000, 4'd0), 4'b0000);

    cur = "blt_n_ne_v";
    p_decode(4'b1010); p_branch(4'b1010); p_fetch(4'b1010);
    run(ins(4'b1011, 2'b10, 6'b000000, 4'd0), 4'b0000);

    cur = "adds_cond_nv";
    p_decode(4'b1010);
`ifndef MC_COND_EXEC_EN
    p_exec(3'b000, 4'b1010); p_aluwb(4'b0001, 1'b0);
`endif
    p_fetch(FL_BEFORE_RST);
    run(ins(4'b1111, 2'b00, 6'b001001, 4'd1), 4'b0001);

    cur = "reset_mid_execr";
    p_decode(FL_BEFORE_RST); p_exec(3'b000, FL_BEFORE_RST);
    run(ins(4'b1110, 2'b00, 6'b001001, 4'd1), 4'b1111);
    reset = 1'b1;
    p_rst(4'b0000); p_rst(4'b0000);
    step(); step();
    reset = 1'b0;
    p_fetch(4'b0000);
    step();

    cur = "adds_after_reset";
    p_decode(4'b0000); p_exec(3'b000, 4'b0000); p_aluwb(4'b1001, 1'b0); p_fetch(4'b1001);
    run(ins(4'b1110, 2'b00, 6'b001001, 4'd6), 4'b1001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
